// File: rtl/complement_code_pkg.sv
// Shared definitions for the sign-magnitude <-> two's-complement converter.
//   MODE_SM2TC / MODE_TC2SM : per-beat conversion direction
//   lane_flags_t            : per-lane status flags produced alongside each converted lane
package complement_code_pkg;

  localparam logic MODE_SM2TC = 1'b0;
  localparam logic MODE_TC2SM = 1'b1;

  typedef struct packed {
    logic sat;
    logic negzero;
  } lane_flags_t;

endpackage

// File: rtl/complement_code_if.sv
// Streaming bus for complement_code_pipe.
//   in_valid/in_ready/in_mode/in_data        : input beat handshake and payload
//   out_valid/out_ready/out_data/out_sat/... : output beat handshake, payload and lane flags
// slave is the converter side, master is the source/sink side.
interface complement_code_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2
);

  logic                      in_valid;
  logic                      in_ready;
  logic                      in_mode;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_sat;
  logic [CHANNELS-1:0]       out_negzero;

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_negzero
  );

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_negzero
  );

endinterface

// File: rtl/complement_code_lane.sv
// Combinational single-lane converter.
//   x_i     : lane input (MSB is the sign bit in both encodings)
//   mode_i  : MODE_SM2TC or MODE_TC2SM
//   y_o     : converted lane
//   flags_o : sat (TC->SM of most-negative value), negzero (SM negative zero)
module complement_code_lane
  import complement_code_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] y_o,
  output lane_flags_t      flags_o
);

  logic             sign;
  logic [WIDTH-2:0] mag;
  logic [WIDTH-1:0] neg;

  assign sign = x_i[WIDTH-1];
  assign mag  = x_i[WIDTH-2:0];

  always_comb begin
    y_o     = x_i;
    flags_o = '0;
    neg     = '0;
    if (sign) begin
      if (mode_i == MODE_SM2TC) begin
        // Negative zero naturally wraps to 0 after truncation.
        neg             = ~{1'b0, mag} + WIDTH'(1);
        y_o             = neg;
        flags_o.negzero = (mag == '0);
      end else begin
        neg = ~x_i + WIDTH'(1);
        if (mag == '0) begin
          // Most-negative TC value has no SM image; clamp to -(2^(W-1)-1).
          y_o         = '1;
          flags_o.sat = 1'b1;
        end else begin
          y_o = {1'b1, neg[WIDTH-2:0]};
        end
      end
    end
  end

endmodule

// File: rtl/complement_code_pipe.sv
// Two-stage multi-lane sign-magnitude <-> two's-complement converter.
//   clk1, rst1 : clock and synchronous active-high reset
//   bus        : valid/ready input and output streams (slave modport)
//   cnt_clear  : synchronous clear of sat_count (wins over increment)
//   sat_count  : saturating count of transferred beats with any lane saturated
// S1 captures the raw beat and its mode; the lane converters sit between S1 and S2;
// S2 is the output register. Output appears two edges after the beat is presented.
module complement_code_pipe
  import complement_code_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk1,
  input  logic             rst1,
  complement_code_if.slave bus,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] sat_count
);

  localparam int unsigned DW = CHANNELS * WIDTH;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_mode_q, s1_mode_d;
  logic [DW-1:0] s1_data_q, s1_data_d;

  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       out_data_q, out_data_d;
  logic [CHANNELS-1:0] out_sat_q, out_sat_d;
  logic [CHANNELS-1:0] out_negzero_q, out_negzero_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic s1_load;
  logic s2_load;
  logic sat_inc;

  logic [DW-1:0]       conv_data;
  logic [CHANNELS-1:0] conv_sat;
  logic [CHANNELS-1:0] conv_negzero;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    lane_flags_t flags;

    complement_code_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .x_i     (s1_data_q[g*WIDTH +: WIDTH]),
      .mode_i  (s1_mode_q),
      .y_o     (conv_data[g*WIDTH +: WIDTH]),
      .flags_o (flags)
    );

    assign conv_sat[g]     = flags.sat;
    assign conv_negzero[g] = flags.negzero;
  end

  always_comb begin
    s2_load = !out_valid_q || bus.out_ready;
    s1_load = !s1_valid_q || s2_load;
    sat_inc = out_valid_q && bus.out_ready && (|out_sat_q);

    s1_valid_d    = s1_valid_q;
    s1_mode_d     = s1_mode_q;
    s1_data_d     = s1_data_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_sat_d     = out_sat_q;
    out_negzero_d = out_negzero_q;
    cnt_d         = cnt_q;

    if (s1_load) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_mode_d = bus.in_mode;
        s1_data_d = bus.in_data;
      end
    end

    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d    = conv_data;
        out_sat_d     = conv_sat;
        out_negzero_d = conv_negzero;
      end else begin
        // Flags only mean something alongside a beat.
        out_sat_d     = '0;
        out_negzero_d = '0;
      end
    end

    if (cnt_clear) begin
      cnt_d = '0;
    end else if (sat_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst1) begin
      s1_valid_q    <= 1'b0;
      s1_mode_q     <= MODE_SM2TC;
      s1_data_q     <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sat_q     <= '0;
      out_negzero_q <= '0;
      cnt_q         <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_mode_q     <= s1_mode_d;
      s1_data_q     <= s1_data_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sat_q     <= out_sat_d;
      out_negzero_q <= out_negzero_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.in_ready    = s1_load;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_sat     = out_sat_q;
  assign bus.out_negzero = out_negzero_q;
  assign sat_count       = cnt_q;

endmodule

// File: tb/tb_complement_code_pipe.sv
// Directed self-checking bench for complement_code_pipe (WIDTH=8, CHANNELS=2, CNT_W=8).
// Lane data is written as {lane1, lane0}.
module tb_complement_code_pipe;

  logic       clk1;
  logic       rst1;
  logic       cnt_clear;
  logic [7:0] sat_count;

  int n_tests;
  int n_fail;

  complement_code_if #(.WIDTH(8), .CHANNELS(2)) bus ();

  complement_code_pipe #(
    .WIDTH    (8),
    .CHANNELS (2),
    .CNT_W    (8)
  ) dut (
    .clk1      (clk1),
    .rst1      (rst1),
    .bus       (bus),
    .cnt_clear (cnt_clear),
    .sat_count (sat_count)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Presents one beat to an idle pipeline and returns the emitted result.
  task automatic run_beat(input logic mode, input logic [15:0] d, output logic [15:0] od,
                          output logic [1:0] os, output logic [1:0] onz, output bit got);
    got = 1'b0;
    od  = '0;
    os  = '0;
    onz = '0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_mode   = mode;
    bus.in_data   = d;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (bus.out_valid) begin
        od  = bus.out_data;
        os  = bus.out_sat;
        onz = bus.out_negzero;
        got = 1'b1;
      end
      tick();
    end
  endtask

  task automatic stream(input logic mode, input logic [15:0] d, input int n);
    bus.out_ready = 1'b1;
    bus.in_mode   = mode;
    bus.in_data   = d;
    bus.in_valid  = 1'b1;
    repeat (n) tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic pulse_clear();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst1 = 1'b1;
    repeat (3) tick();
    rst1 = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
    end
    n_tests++;
    if (bus.out_data !== 16'h0000 || bus.out_sat !== 2'b00 || bus.out_negzero !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_outputs: got data %h sat %b nz %b, required 0000 00 00",
               bus.out_data, bus.out_sat, bus.out_negzero);
    end
    n_tests++;
    if (sat_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_sat_count: got %0d, required 0", sat_count);
    end
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_sm2tc();
    logic [15:0] din[3];
    logic [15:0] dexp[3];
    logic [1:0]  nzexp[3];
    logic [15:0] od;
    logic [1:0]  os, onz;
    bit          got;
    din[0] = 16'h0585; dexp[0] = 16'h05FB; nzexp[0] = 2'b00;
    din[1] = 16'h0080; dexp[1] = 16'h0000; nzexp[1] = 2'b01;
    din[2] = 16'h7FFF; dexp[2] = 16'h7F81; nzexp[2] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      run_beat(1'b0, din[i], od, os, onz, got);
      n_tests++;
      if (!got || od !== dexp[i] || os !== 2'b00 || onz !== nzexp[i]) begin
        n_fail++;
        $display("FAIL sm2tc_%0d: got valid %b data %h sat %b nz %b, required data %h sat 00 nz %b",
                 i, got, od, os, onz, dexp[i], nzexp[i]);
      end
    end
  endtask

  task automatic test_tc2sm();
    logic [15:0] od;
    logic [1:0]  os, onz;
    bit          got;
    pulse_clear();
    run_beat(1'b1, 16'h80FB, od, os, onz, got);
    n_tests++;
    if (!got || od !== 16'hFF85 || os !== 2'b10 || onz !== 2'b00) begin
      n_fail++;
      $display("FAIL tc2sm_sat: got valid %b data %h sat %b nz %b, required data FF85 sat 10 nz 00",
               got, od, os, onz);
    end
    n_tests++;
    if (sat_count !== 8'd1) begin
      n_fail++; $display("FAIL tc2sm_count: got %0d, required 1", sat_count);
    end
    run_beat(1'b1, 16'h7F81, od, os, onz, got);
    n_tests++;
    if (!got || od !== 16'h7FFF || os !== 2'b00 || onz !== 2'b00) begin
      n_fail++;
      $display("FAIL tc2sm_plain: got valid %b data %h sat %b nz %b, required data 7FFF sat 00 nz 00",
               got, od, os, onz);
    end
    n_tests++;
    if (sat_count !== 8'd1) begin
      n_fail++; $display("FAIL tc2sm_count_hold: got %0d, required 1", sat_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] din[4];
    logic [15:0] dexp[4];
    logic        mode[4];
    int          k, first, last, not_ready;
    din[0] = 16'h0181; dexp[0] = 16'h01FF; mode[0] = 1'b0;
    din[1] = 16'h7F82; dexp[1] = 16'h7FFE; mode[1] = 1'b0;
    din[2] = 16'hFF90; dexp[2] = 16'h81F0; mode[2] = 1'b0;
    din[3] = 16'h10F0; dexp[3] = 16'h1090; mode[3] = 1'b1;
    k = 0; first = -1; last = -1; not_ready = 0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (bus.out_valid) begin
        if (k < 4) begin
          n_tests++;
          if (bus.out_data !== dexp[k]) begin
            n_fail++;
            $display("FAIL b2b_data_%0d: got %h, required %h", k, bus.out_data, dexp[k]);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        k++;
      end
      if (cyc < 4) begin
        bus.in_valid = 1'b1;
        bus.in_mode  = mode[cyc];
        bus.in_data  = din[cyc];
        if (!bus.in_ready) not_ready++;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
    end
    n_tests++;
    if (k !== 4 || first !== 2 || last !== 5 || not_ready !== 0) begin
      n_fail++;
      $display("FAIL b2b_timing: got beats %0d first %0d last %0d stalls %0d, required 4 2 5 0",
               k, first, last, not_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] din[4];
    logic [15:0] dexp[4];
    logic        mode[4];
    logic [15:0] held;
    bit          have_held, in_fire;
    int          j, k, unstable;
    din[0] = 16'h0083; dexp[0] = 16'h00FD; mode[0] = 1'b0;
    din[1] = 16'h1184; dexp[1] = 16'h11FC; mode[1] = 1'b0;
    din[2] = 16'h02FE; dexp[2] = 16'h0282; mode[2] = 1'b1;
    din[3] = 16'h8580; dexp[3] = 16'hFB00; mode[3] = 1'b0;
    j = 0; k = 0; unstable = 0; have_held = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && (k < 4 || j < 4); cyc++) begin
      bus.out_ready = (cyc >= 5);
      bus.in_valid  = (j < 4);
      if (j < 4) begin
        bus.in_mode = mode[j];
        bus.in_data = din[j];
      end
      #1;
      if (cyc == 4) begin
        n_tests++;
        if (j !== 2 || bus.in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_stall: got accepted %0d in_ready %b, required 2 0", j, bus.in_ready);
        end
      end
      in_fire = bus.in_valid && bus.in_ready;
      if (bus.out_valid && !bus.out_ready) begin
        if (!have_held) begin
          held      = bus.out_data;
          have_held = 1'b1;
        end else if (bus.out_data !== held) begin
          unstable++;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (k < 4) begin
          n_tests++;
          if (bus.out_data !== dexp[k]) begin
            n_fail++;
            $display("FAIL bp_data_%0d: got %h, required %h", k, bus.out_data, dexp[k]);
          end
        end
        k++;
      end
      tick();
      if (in_fire) j++;
    end
    bus.in_valid = 1'b0;
    n_tests++;
    if (k !== 4 || unstable !== 0 || held !== dexp[0]) begin
      n_fail++;
      $display("FAIL bp_hold: got beats %0d unstable %0d held %h, required 4 0 %h",
               k, unstable, held, dexp[0]);
    end
    k = 0;
    repeat (4) begin
      if (bus.out_valid) k++;
      tick();
    end
    n_tests++;
    if (k !== 0) begin
      n_fail++; $display("FAIL bp_no_dup: got %0d extra beats, required 0", k);
    end
  endtask

  task automatic test_counter();
    logic [15:0] od;
    logic [1:0]  os, onz;
    bit          got;
    pulse_clear();
    stream(1'b0, 16'h0080, 5);
    n_tests++;
    if (sat_count !== 8'd0) begin
      n_fail++; $display("FAIL cnt_no_sat: got %0d, required 0", sat_count);
    end
    stream(1'b1, 16'h0080, 10);
    n_tests++;
    if (sat_count !== 8'd10) begin
      n_fail++; $display("FAIL cnt_10: got %0d, required 10", sat_count);
    end
    stream(1'b1, 16'h0080, 290);
    n_tests++;
    if (sat_count !== 8'd255) begin
      n_fail++; $display("FAIL cnt_sat: got %0d, required 255", sat_count);
    end
    stream(1'b1, 16'h8000, 5);
    n_tests++;
    if (sat_count !== 8'd255) begin
      n_fail++; $display("FAIL cnt_hold: got %0d, required 255", sat_count);
    end
    // Clear in the very cycle a saturating beat transfers.
    bus.out_ready = 1'b1;
    bus.in_mode   = 1'b1;
    bus.in_data   = 16'h0080;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (bus.out_valid) got = 1'b1;
      else tick();
    end
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    n_tests++;
    if (!got || sat_count !== 8'd0) begin
      n_fail++; $display("FAIL cnt_clear_wins: got valid %b count %0d, required 1 0", got, sat_count);
    end
    run_beat(1'b1, 16'h8000, od, os, onz, got);
    n_tests++;
    if (!got || os !== 2'b10 || sat_count !== 8'd1) begin
      n_fail++;
      $display("FAIL cnt_after_clear: got valid %b sat %b count %0d, required 1 10 1",
               got, os, sat_count);
    end
  endtask

  task automatic test_reset_flush();
    int seen;
    bus.out_ready = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0585;
    tick();
    bus.in_data = 16'h0182;
    tick();
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre: got out_valid %b, required 1", bus.out_valid);
    end
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 16'h0000
        || sat_count !== 8'd0) begin
      n_fail++;
      $display("FAIL flush_state: got valid %b ready %b data %h count %0d, required 0 1 0000 0",
               bus.out_valid, bus.in_ready, bus.out_data, sat_count);
    end
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      if (bus.out_valid) seen++;
      tick();
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL flush_ghost: got %0d beats, required 0", seen);
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst1          = 1'b1;
    cnt_clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_sm2tc();
    test_tc2sm();
    test_back_to_back();
    test_backpressure();
    test_counter();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
